// File: rtl/translation_pkg.sv
// rtl/translation_pkg.sv - shared widths, limits, FSM encoding and subtract helpers
package translation_pkg;

    localparam int X_W  = 12;
    localparam int Y_W  = 11;
    localparam int D_W  = 5;
    localparam int WX_W = 12;
    localparam int WY_W = 12;
    localparam int PAYLOAD_W = 2 + WX_W + WY_W;

    localparam logic signed [WX_W-1:0] X_MAX = 12'sd2047;
    localparam logic signed [WX_W-1:0] X_MIN = -12'sd2048;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DRAIN  = 2'd2
    } state_t;

    // x - d in 13 bits, then clamp to the 12-bit world range; returns {clip, x}
    function automatic logic [WX_W:0] sub_sat_x(input logic signed [X_W-1:0] x,
                                                input logic signed [D_W-1:0] d);
        logic [X_W:0] diff;
        diff = {x[X_W-1], x} - {{(X_W+1-D_W){d[D_W-1]}}, d};
        // the two top bits disagree exactly when the result left the 12-bit range
        if (diff[X_W] != diff[X_W-1]) begin
            sub_sat_x = diff[X_W] ? {1'b1, X_MIN} : {1'b1, X_MAX};
        end else begin
            sub_sat_x = {1'b0, diff[WX_W-1:0]};
        end
    endfunction

    // y widened to 12 bits before subtracting, so the result always fits
    function automatic logic [WY_W-1:0] sub_y(input logic signed [Y_W-1:0] y,
                                              input logic signed [D_W-1:0] d);
        sub_y = {y[Y_W-1], y} - {{(WY_W-D_W){d[D_W-1]}}, d};
    endfunction

endpackage

// File: rtl/point_fifo.sv
// rtl/point_fifo.sv - synchronous point FIFO with registered storage and head read-out
module point_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 26
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic [W-1:0]               wdata,
    input  logic                       pop,
    output logic [W-1:0]               rdata,
    output logic                       valid,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    // storage, pointers and occupancy; cleared so the head reads zero after reset
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    assign rdata = mem[rd_ptr];
    assign valid = (count != '0);

endmodule

// File: rtl/inverse_translation.sv
// rtl/inverse_translation.sv - screen-to-world point translation with frame-deferred offset reload
module inverse_translation
    import translation_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic signed [D_W-1:0]  dist_in,
    input  logic                   load_dist,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic signed [X_W-1:0]  in_x,
    input  logic signed [Y_W-1:0]  in_y,
    input  logic                   in_last,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic signed [WX_W-1:0] out_x,
    output logic signed [WY_W-1:0] out_y,
    output logic                   out_last,
    output logic                   out_clip,
    output logic                   busy
);

    localparam int CW = $clog2(DEPTH) + 1;

    state_t                state;
    state_t                state_next;
    logic signed [D_W-1:0] dist_reg;
    logic signed [D_W-1:0] pend_dist;
    logic                  pend_valid;
    logic [CW-1:0]         count;
    logic                  accept;
    logic                  pop;
    logic                  drain_done;
    logic                  direct_load;
    logic [WX_W:0]         x_res;
    logic [WY_W-1:0]       y_res;
    logic [PAYLOAD_W-1:0]  wdata;
    logic [PAYLOAD_W-1:0]  rdata;

    assign in_ready    = (state != DRAIN) && (count < CW'(DEPTH)) && !(state == IDLE && load_dist);
    assign accept      = in_valid && in_ready;
    assign pop         = out_valid && out_ready;
    // DRAIN never pushes, so the FIFO is empty after this edge iff it is empty now or loses its last entry
    assign drain_done  = (state == DRAIN) && ((count == '0) || (count == CW'(1) && pop));
    assign direct_load = load_dist && (state == IDLE) && (count == '0);

    assign x_res = sub_sat_x(in_x, dist_reg);
    assign y_res = sub_y(in_y, dist_reg);
    assign wdata = {in_last, x_res[WX_W], x_res[WX_W-1:0], y_res};

    point_fifo #(
        .DEPTH (DEPTH),
        .W     (PAYLOAD_W)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (accept),
        .wdata (wdata),
        .pop   (pop),
        .rdata (rdata),
        .valid (out_valid),
        .count (count)
    );

    assign out_last = rdata[PAYLOAD_W-1];
    assign out_clip = rdata[PAYLOAD_W-2];
    assign out_x    = rdata[WX_W+WY_W-1:WY_W];
    assign out_y    = rdata[WY_W-1:0];
    assign busy     = (state != IDLE) || (count != '0);

    // frame state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // frame progression: first point opens a frame, the last point closes it, drain ends it
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_next = in_last ? DRAIN : STREAM;
                end
            end
            STREAM: begin
                if (accept && in_last) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (drain_done) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // offset register: immediate load between frames, otherwise held until the frame boundary
    always_ff @(posedge clk) begin
        if (reset) begin
            dist_reg   <= '0;
            pend_dist  <= '0;
            pend_valid <= 1'b0;
        end else if (drain_done) begin
            if (load_dist) begin
                dist_reg <= dist_in;
            end else if (pend_valid) begin
                dist_reg <= pend_dist;
            end
            pend_valid <= 1'b0;
        end else if (direct_load) begin
            dist_reg <= dist_in;
        end else if (load_dist) begin
            pend_dist  <= dist_in;
            pend_valid <= 1'b1;
        end
    end

endmodule

// File: tb/tb_inverse_translation.sv
// tb/tb_inverse_translation.sv - scoreboard bench for inverse_translation
module tb_inverse_translation;

    typedef struct packed {
        logic              last;
        logic              clip;
        logic signed [11:0] x;
        logic signed [11:0] y;
    } exp_t;

    logic               clk = 1'b0;
    logic               reset;
    logic signed [4:0]  dist_in;
    logic               load_dist;
    logic               in_valid;
    logic               in_ready;
    logic signed [11:0] in_x;
    logic signed [10:0] in_y;
    logic               in_last;
    logic               out_valid;
    logic               out_ready;
    logic signed [11:0] out_x;
    logic signed [11:0] out_y;
    logic               out_last;
    logic               out_clip;
    logic               busy;

    int   checks = 0;
    int   errors = 0;
    int   accepted = 0;
    exp_t exp_q[$];

    inverse_translation #(.DEPTH(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .dist_in   (dist_in),
        .load_dist (load_dist),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_x      (in_x),
        .in_y      (in_y),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_x     (out_x),
        .out_y     (out_y),
        .out_last  (out_last),
        .out_clip  (out_clip),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    // monitor: every head transfer is compared with the oldest expected point
    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL out_unexpected: got x=%0d y=%0d last=%0b clip=%0b, expected no output",
                         out_x, out_y, out_last, out_clip);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (out_x !== e.x || out_y !== e.y || out_last !== e.last || out_clip !== e.clip) begin
                    errors++;
                    $display("FAIL out_point: got x=%0d y=%0d last=%0b clip=%0b, expected x=%0d y=%0d last=%0b clip=%0b",
                             out_x, out_y, out_last, out_clip, e.x, e.y, e.last, e.clip);
                end
            end
        end
    end

    // present one point and queue its expected result at the cycle it is accepted
    task automatic send(input int x, input int y, input bit last,
                        input int ex, input int ey, input bit eclip, input int tmo);
        exp_t e;
        in_x     = 12'(x);
        in_y     = 11'(y);
        in_last  = last;
        in_valid = 1'b1;
        for (int n = 0; n < tmo; n++) begin
            @(negedge clk);
            if (in_ready) begin
                e.last = last;
                e.clip = eclip;
                e.x    = 12'(ex);
                e.y    = 12'(ey);
                exp_q.push_back(e);
                @(posedge clk);
                #1;
                in_valid = 1'b0;
                accepted++;
                return;
            end
        end
        checks++;
        errors++;
        $display("FAIL send_timeout: got in_ready=0 for %0d cycles, expected acceptance of x=%0d", tmo, x);
        in_valid = 1'b0;
    endtask

    task automatic load(input int v, input bit expect_block);
        load_dist = 1'b1;
        dist_in   = 5'(v);
        @(negedge clk);
        if (expect_block) check("in_ready_during_load", int'(in_ready), 0);
        @(posedge clk);
        #1;
        load_dist = 1'b0;
    endtask

    task automatic wait_empty(input int tmo);
        for (int n = 0; n < tmo; n++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !busy) begin
                @(posedge clk);
                #1;
                return;
            end
        end
        checks++;
        errors++;
        $display("FAIL drain_timeout: got %0d points outstanding busy=%0b, expected 0 and 0", exp_q.size(), busy);
    endtask

    initial begin
        reset     = 1'b1;
        dist_in   = '0;
        load_dist = 1'b0;
        in_valid  = 1'b0;
        in_x      = '0;
        in_y      = '0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        // reset state
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_out_x", int'(out_x), 0);
        check("rst_out_y", int'(out_y), 0);
        check("rst_out_last", int'(out_last), 0);
        check("rst_out_clip", int'(out_clip), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_in_ready", int'(in_ready), 1);

        // basic: dist 5, single-point frame
        load(5, 1'b1);
        out_ready = 1'b1;
        send(100, 50, 1'b1, 95, 45, 1'b0, 50);
        check("basic_out_valid", int'(out_valid), 1);
        check("basic_busy_before_pop", int'(busy), 1);
        @(posedge clk);
        #1;
        check("basic_busy_after_pop", int'(busy), 0);
        check("basic_out_valid_after_pop", int'(out_valid), 0);

        // saturation at both ends, y widening
        load(-16, 1'b1);
        send(2040, 1023, 1'b0, 2047, 1039, 1'b1, 50);
        send(-2040, -5, 1'b1, -2024, 11, 1'b0, 50);
        wait_empty(50);
        load(15, 1'b1);
        send(2047, 0, 1'b0, 2032, -15, 1'b0, 50);
        send(-2040, -1024, 1'b1, -2048, -1039, 1'b1, 50);
        wait_empty(50);

        // backpressure: 6 points into a 4-deep FIFO
        load(2, 1'b1);
        out_ready = 1'b0;
        accepted  = 0;
        fork
            begin
                for (int i = 0; i < 6; i++) begin
                    send(i * 10, i, i == 5, i * 10 - 2, i - 2, 1'b0, 400);
                end
            end
        join_none
        repeat (12) @(posedge clk);
        #1;
        check("bp_accepted", accepted, 4);
        check("bp_in_ready", int'(in_ready), 0);
        out_ready = 1'b1;
        for (int n = 0; n < 100 && accepted < 6; n++) @(posedge clk);
        #1;
        check("bp_accepted_total", accepted, 6);
        wait_empty(50);

        // deferred load: two mid-frame requests, last one wins at the boundary
        load(3, 1'b1);
        send(10, 10, 1'b0, 7, 7, 1'b0, 50);
        load(7, 1'b0);
        load(9, 1'b0);
        send(20, 20, 1'b0, 17, 17, 1'b0, 50);
        send(30, 30, 1'b1, 27, 27, 1'b0, 50);
        wait_empty(50);
        send(40, 40, 1'b1, 31, 31, 1'b0, 50);
        wait_empty(50);

        // DRAIN blocks new points until the FIFO is empty
        out_ready = 1'b0;
        send(1, 1, 1'b1, -8, -8, 1'b0, 50);
        in_x     = 12'sd5;
        in_y     = 11'sd5;
        in_last  = 1'b0;
        in_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("drain_in_ready", int'(in_ready), 0);
            check("drain_busy", int'(busy), 1);
        end
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        wait_empty(50);
        check("drain_released_in_ready", int'(in_ready), 1);

        // reset mid-frame with 3 buffered points and a pending load
        out_ready = 1'b0;
        send(1, 2, 1'b0, -8, -7, 1'b0, 50);
        send(3, 4, 1'b0, -6, -5, 1'b0, 50);
        send(5, 6, 1'b0, -4, -3, 1'b0, 50);
        load(4, 1'b0);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        exp_q.delete();
        check("mid_rst_out_valid", int'(out_valid), 0);
        check("mid_rst_busy", int'(busy), 0);
        check("mid_rst_in_ready", int'(in_ready), 1);
        check("mid_rst_out_x", int'(out_x), 0);
        out_ready = 1'b1;
        send(50, 50, 1'b1, 50, 50, 1'b0, 50);
        wait_empty(50);
        send(60, -60, 1'b1, 60, -60, 1'b0, 50);
        wait_empty(50);
        check("final_queue_empty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no completion, expected finish within 200000 time units");
        $fatal(1);
    end

endmodule
